// File: rtl/present_pkg.sv
// Shared PRESENT constants: S-box table, state geometry, FSM encoding and pLayer bit mapping.
package present_pkg;

  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;

  // Entry x is S(x); entry 15 is listed first because the array is packed.
  localparam logic [15:0][3:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int player_idx(input int i);
    return (i == STATE_W - 1) ? i : (16 * i) % (STATE_W - 1);
  endfunction

endpackage

// File: rtl/present_sbox4.sv
// Combinational 4-bit PRESENT S-box lookup.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = SBOX[i_nib];

endmodule

// File: rtl/present_slayer_serial.sv
// Serialized PRESENT substitution layer, NPC nibbles per cycle, 16/NPC cycles latency.
// Optional pLayer on the output wiring when PRESENT_PLAYER_EN is defined.
module present_slayer_serial
  import present_pkg::*;
#(
  parameter int NPC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int STEPS = NIBBLES / NPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SUB_W = 4 * NPC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
      $error("present_slayer_serial: NPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t             r_fsm;
  state_t             w_fsm_nxt;
  logic [STATE_W-1:0] r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic [SUB_W-1:0]   w_sub;
  logic [STATE_W-1:0] w_rot;

  genvar g;
  generate
    for (g = 0; g < NPC; g++) begin : g_sbox
      present_sbox4 u_sbox (
        .i_nib (r_work[4*g +: 4]),
        .o_nib (w_sub[4*g +: 4])
      );
    end

    // Substituted nibbles re-enter at the top so 16/NPC steps restore positions.
    if (NPC == NIBBLES) begin : g_rot_full
      assign w_rot = w_sub;
    end else begin : g_rot_part
      assign w_rot = {w_sub, r_work[STATE_W-1:SUB_W]};
    end
  endgenerate

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid) w_fsm_nxt = SUB;
      SUB:     if (r_cnt == LAST) w_fsm_nxt = DONE;
      DONE:    if (out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= IDLE;
      r_work <= '0;
      r_cnt  <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == IDLE && in_valid) begin
        r_work <= in_state;
        r_cnt  <= '0;
      end else if (r_fsm == SUB) begin
        r_work <= w_rot;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm != IDLE);

`ifdef PRESENT_PLAYER_EN
  logic [STATE_W-1:0] w_perm;
  generate
    for (g = 0; g < STATE_W; g++) begin : g_player
      assign w_perm[player_idx(g)] = r_work[g];
    end
  endgenerate
  assign out_state = w_perm;
`else
  assign out_state = r_work;
`endif

endmodule

// File: tb/tb_present_slayer_serial.sv
// Directed bench for present_slayer_serial (NPC=1 and NPC=4 instances).
module tb_present_slayer_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in1_valid = 1'b0, in1_ready, out1_valid, out1_ready = 1'b0, busy1;
  logic [63:0] in1_state = '0, out1_state;
  logic        in4_valid = 1'b0, in4_ready, out4_valid, out4_ready = 1'b0, busy4;
  logic [63:0] in4_state = '0, out4_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  present_slayer_serial #(.NPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_state(in1_state),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_state(out1_state),
    .busy(busy1)
  );

  present_slayer_serial #(.NPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_state(in4_state),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_state(out4_state),
    .busy(busy4)
  );

  function automatic logic [63:0] exp_of(input logic [63:0] sub);
`ifdef PRESENT_PLAYER_EN
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16 * i) % 63] = sub[i];
    return p;
`else
    return sub;
`endif
  endfunction

  task automatic accept1(input logic [63:0] x);
    in1_state = x;
    in1_valid = 1'b1;
    @(posedge clk); #1;
    in1_valid = 1'b0;
  endtask

  task automatic wait_done1(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out1_valid) begin lat = n; break; end
    end
  endtask

  task automatic consume1();
    out1_ready = 1'b1;
    @(posedge clk); #1;
    out1_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in1_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in1_ready); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out1_valid); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy1); end
    checks++; if (out1_state !== 64'h0) begin failures++; $display("FAIL reset_out_state got=%h want=0", out1_state); end
    checks++; if (in4_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready4 got=%b want=1", in4_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat;
    accept1(64'h0);
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b want=1", busy1); end
    wait_done1(lat);
    checks++; if (lat !== 16) begin failures++; $display("FAIL zero_latency got=%0d want=16", lat); end
    checks++; if (out1_state !== exp_of(64'hCCCCCCCCCCCCCCCC)) begin
      failures++; $display("FAIL zero_out got=%h want=%h", out1_state, exp_of(64'hCCCCCCCCCCCCCCCC)); end
    consume1();
  endtask

  task automatic test_pattern();
    int lat;
    accept1(64'h0123456789ABCDEF);
    wait_done1(lat);
    checks++; if (lat !== 16) begin failures++; $display("FAIL pat_latency got=%0d want=16", lat); end
    checks++; if (out1_state !== exp_of(64'hC56B90AD3EF84712)) begin
      failures++; $display("FAIL pat_out got=%h want=%h", out1_state, exp_of(64'hC56B90AD3EF84712)); end
    consume1();
  endtask

  task automatic test_npc4();
    int lat;
    lat = -1;
    in4_state = 64'h0123456789ABCDEF;
    in4_valid = 1'b1;
    @(posedge clk); #1;
    in4_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out4_valid) begin lat = n; break; end
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL npc4_latency got=%0d want=4", lat); end
    checks++; if (out4_state !== exp_of(64'hC56B90AD3EF84712)) begin
      failures++; $display("FAIL npc4_out got=%h want=%h", out4_state, exp_of(64'hC56B90AD3EF84712)); end
    out4_ready = 1'b1;
    @(posedge clk); #1;
    out4_ready = 1'b0;
    checks++; if (in4_ready !== 1'b1) begin failures++; $display("FAIL npc4_idle got=%b want=1", in4_ready); end
  endtask

  task automatic test_backpressure();
    int lat;
    accept1(64'h0123456789ABCDEF);
    wait_done1(lat);
    for (int c = 0; c < 5; c++) begin
      in1_valid = c[0];
      in1_state = 64'hFFFFFFFFFFFFFFFF;
      checks++; if (out1_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b want=1", c, out1_valid); end
      checks++; if (out1_state !== exp_of(64'hC56B90AD3EF84712)) begin
        failures++; $display("FAIL bp_state[%0d] got=%h want=%h", c, out1_state, exp_of(64'hC56B90AD3EF84712)); end
      checks++; if (in1_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in1_ready); end
      @(posedge clk); #1;
    end
    in1_valid = 1'b0;
    consume1();
    checks++; if (in1_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", in1_ready); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", out1_valid); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL bp_release_busy got=%b want=0", busy1); end
  endtask

  task automatic test_reset_mid();
    int lat;
    accept1(64'h0123456789ABCDEF);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b want=0", out1_valid); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy1); end
    checks++; if (out1_state !== 64'h0) begin failures++; $display("FAIL rmid_state got=%h want=0", out1_state); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in1_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b want=1", in1_ready); end
    checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid_after got=%b want=0", out1_valid); end
    accept1(64'hFFFFFFFFFFFFFFFF);
    wait_done1(lat);
    checks++; if (lat !== 16) begin failures++; $display("FAIL rmid_latency got=%0d want=16", lat); end
    checks++; if (out1_state !== exp_of(64'h2222222222222222)) begin
      failures++; $display("FAIL rmid_out got=%h want=%h", out1_state, exp_of(64'h2222222222222222)); end
    consume1();
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    logic [63:0] res[2];
    int nacc, nres;
    logic acc, con;
    logic [63:0] cap;
    nacc = 0; nres = 0;
    in1_state = 64'h0123456789ABCDEF;
    in1_valid = 1'b1;
    out1_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
      acc = in1_valid && in1_ready;
      con = out1_valid && out1_ready;
      cap = out1_state;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        in1_state = 64'hFFFFFFFFFFFFFFFF;
        if (nacc == 2) in1_valid = 1'b0;
      end
      if (con) begin res[nres] = cap; nres++; end
    end
    in1_valid = 1'b0;
    out1_ready = 1'b0;
    checks++; if (nacc !== 2) begin failures++; $display("FAIL b2b_accepts got=%0d want=2", nacc); end
    checks++; if (nres !== 2) begin failures++; $display("FAIL b2b_results got=%0d want=2", nres); end
    if (nacc == 2) begin
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 18) begin
        failures++; $display("FAIL b2b_interval got=%0d want=18", acc_cyc[1] - acc_cyc[0]); end
    end
    if (nres == 2) begin
      checks++; if (res[0] !== exp_of(64'hC56B90AD3EF84712)) begin
        failures++; $display("FAIL b2b_res0 got=%h want=%h", res[0], exp_of(64'hC56B90AD3EF84712)); end
      checks++; if (res[1] !== exp_of(64'h2222222222222222)) begin
        failures++; $display("FAIL b2b_res1 got=%h want=%h", res[1], exp_of(64'h2222222222222222)); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_pattern();
    test_npc4();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
